// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the snooping bus controller.
// Bus field positions, widths and the controller FSM states.
package snoop_bus_pkg;

    localparam int BUS_W  = 13;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 4;

    localparam int BUS_WB      = 12;
    localparam int BUS_ABORT   = 11;
    localparam int BUS_REPLY   = 10;
    localparam int BUS_RM      = 9;
    localparam int BUS_WM      = 8;
    localparam int BUS_INV     = 7;
    localparam int BUS_ADDR_HI = 6;
    localparam int BUS_ADDR_LO = 4;
    localparam int BUS_DATA_HI = 3;
    localparam int BUS_DATA_LO = 0;

    typedef enum logic [2:0] {
        IDLE,
        BCAST,
        SNOOP,
        MEM,
        REPLY
    } state_t;

    typedef struct packed {
        logic [2:0]        op;
        logic [ADDR_W-1:0] addr;
    } msg_t;

    function automatic logic is_req(input logic [BUS_W-1:0] s);
        return s[BUS_REPLY] && $onehot(s[BUS_RM:BUS_INV]);
    endfunction

endpackage

// File: rtl/snoop_bus_controller_rr_arbiter.sv
// Combinational round-robin pick: first pending requester
// at or after the pointer, wrapping past N-1.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          found
);

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && pending[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                index = IW'((int'(ptr) + k) % N);
                grant[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snoop_bus_controller.sv
// Snooping bus controller: captures CPU requests, arbitrates,
// broadcasts, gathers snoop data, services memory and replies.
import snoop_bus_pkg::*;

module snoop_bus_controller #(
    parameter int N_CPU   = 3,
    parameter int MEM_LAT = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [BUS_W*N_CPU-1:0] cpu_bus_out,
    output logic [BUS_W*N_CPU-1:0] cpu_bus_in,
    output logic [N_CPU-1:0]       grant,
    output logic                   busy,
    output logic                   err_overflow
);

    localparam int IW    = $clog2(N_CPU);
    localparam int CW    = $clog2(MEM_LAT + 1);
    localparam int MEM_D = 1 << ADDR_W;

    state_t state, state_d;

    logic [BUS_W-1:0]  slice [N_CPU];
    logic [N_CPU-1:0]  pending;
    msg_t              msg [N_CPU];
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     g_idx;
    logic [IW-1:0]     arb_idx;
    logic [N_CPU-1:0]  arb_grant;
    logic              arb_found;
    logic [2:0]        g_op;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] snoop_data;
    logic [DATA_W-1:0] reply_data;
    logic              snoop_hit;
    logic [DATA_W-1:0] mem [MEM_D];
    logic [CW-1:0]     cnt;
    logic              mem_last;

    logic [BUS_W*N_CPU-1:0] bus_in_d;

    for (genvar i = 0; i < N_CPU; i++) begin : g_slice
        assign slice[i] = cpu_bus_out[i*BUS_W +: BUS_W];
    end

    rr_arbiter #(
        .N  (N_CPU),
        .IW (IW)
    ) u_arb (
        .pending (pending),
        .ptr     (ptr),
        .grant   (arb_grant),
        .index   (arb_idx),
        .found   (arb_found)
    );

    // Lowest-index snooper asserting write_back or abort wins.
    always_comb begin
        snoop_hit  = 1'b0;
        snoop_data = '0;
        for (int i = N_CPU - 1; i >= 0; i--) begin
            if (i != int'(g_idx) &&
                (slice[i][BUS_WB] || slice[i][BUS_ABORT])) begin
                snoop_hit  = 1'b1;
                snoop_data = slice[i][BUS_DATA_HI:BUS_DATA_LO];
            end
        end
    end

    assign mem_last = (cnt == CW'(MEM_LAT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (arb_found) state_d = BCAST;
            BCAST: state_d = SNOOP;
            SNOOP: begin
                if (g_op[2] && !snoop_hit) state_d = MEM;
                else                       state_d = REPLY;
            end
            MEM:   if (mem_last) state_d = REPLY;
            REPLY: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_in_d   = '0;
        busy       = (state != IDLE);
        reply_data = g_op[2] ? rdata : '0;
        unique case (state)
            BCAST: begin
                for (int i = 0; i < N_CPU; i++) begin
                    if (i != int'(g_idx)) begin
                        bus_in_d[i*BUS_W +: BUS_W] =
                            {3'b000, g_op, g_addr, {DATA_W{1'b0}}};
                    end
                end
            end
            REPLY: begin
                bus_in_d[int'(g_idx)*BUS_W +: BUS_W] =
                    {3'b001, g_op, g_addr, reply_data};
            end
            default: ;
        endcase
    end

    // Capture runs every cycle; clearing the served entry wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            err_overflow <= 1'b0;
            for (int i = 0; i < N_CPU; i++) msg[i] <= '0;
        end else begin
            for (int i = 0; i < N_CPU; i++) begin
                if (is_req(slice[i])) begin
                    if (pending[i]) begin
                        err_overflow <= 1'b1;
                    end else begin
                        pending[i] <= 1'b1;
                        msg[i]     <= slice[i][BUS_RM:BUS_ADDR_LO];
                    end
                end
            end
            if (state == REPLY) pending[g_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cpu_bus_in <= '0;
            grant      <= '0;
            ptr        <= '0;
            g_idx      <= '0;
            g_op       <= '0;
            g_addr     <= '0;
            rdata      <= '0;
            cnt        <= '0;
            for (int i = 0; i < MEM_D; i++) mem[i] <= DATA_W'(i);
        end else begin
            cpu_bus_in <= bus_in_d;
            unique case (state)
                IDLE: begin
                    if (arb_found) begin
                        g_idx  <= arb_idx;
                        g_op   <= msg[arb_idx].op;
                        g_addr <= msg[arb_idx].addr;
                        grant  <= arb_grant;
                        rdata  <= '0;
                        cnt    <= '0;
                    end
                end
                SNOOP: begin
                    if (snoop_hit) begin
                        mem[g_addr] <= snoop_data;
                        rdata       <= snoop_data;
                    end
                end
                MEM: begin
                    cnt <= cnt + 1'b1;
                    if (mem_last) rdata <= mem[g_addr];
                end
                REPLY: begin
                    grant <= '0;
                    ptr   <= (int'(g_idx) == N_CPU - 1) ? '0
                                                        : g_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
